// File: rtl/apu_pkg.sv
// -----------------------------------------------------------------------------
// apu_pkg
//   Shared APU definitions used by the channel-1 sweep unit and its
//   combinational calculator.
//
//   Contents:
//     FREQ_W_DEF / PER_W_DEF / SHIFT_W_DEF : default field widths
//     SWEEP_TIMER_W                        : width of the sweep period timer
//     SWEEP_PERIOD0_RELOAD                 : timer reload used when period==0
//     sweep_state_e                        : sweep FSM state encoding
// -----------------------------------------------------------------------------
package apu_pkg;

   localparam int FREQ_W_DEF  = 11;
   localparam int PER_W_DEF   = 3;
   localparam int SHIFT_W_DEF = 3;

   // Timer must hold the largest reload (8), so it is one bit wider than
   // the period field.
   localparam int SWEEP_TIMER_W        = 4;
   localparam int SWEEP_PERIOD0_RELOAD = 8;

   typedef enum logic [1:0] {
      SWEEP_IDLE    = 2'd0,
      SWEEP_CHECK   = 2'd1,
      SWEEP_APPLY   = 2'd2,
      SWEEP_RECHECK = 2'd3
   } sweep_state_e;

endpackage : apu_pkg

// File: rtl/ch1_sweep_calc.sv
// -----------------------------------------------------------------------------
// ch1_sweep_calc
//   Purely combinational sweep arithmetic: shifts the shadow frequency right
//   by the shift field and adds or subtracts the result.
//
//   Ports:
//     shadow   in  [FREQ_W-1:0]  shadow frequency
//     negate   in  1             1 = subtract the shifted value
//     shift    in  [SHIFT_W-1:0] right-shift amount
//     new_freq out [FREQ_W:0]    candidate frequency including carry bit
//     overflow out 1             addition exceeded FREQ_W bits
// -----------------------------------------------------------------------------
module ch1_sweep_calc
   import apu_pkg::*;
#(
   parameter int FREQ_W  = FREQ_W_DEF,
   parameter int SHIFT_W = SHIFT_W_DEF
) (
   input  logic [FREQ_W-1:0]  shadow,
   input  logic               negate,
   input  logic [SHIFT_W-1:0] shift,
   output logic [FREQ_W:0]    new_freq,
   output logic               overflow
);

   logic [FREQ_W-1:0] delta;

   // NOTE: every output of a combinational block is assigned on every path
   // (here unconditionally up front) so no latch can be inferred.
   always_comb begin
      delta    = shadow >> shift;
      new_freq = {1'b0, shadow} + {1'b0, delta};
      if (negate) begin
         // delta <= shadow always, so the subtraction cannot wrap.
         new_freq = {1'b0, shadow} - {1'b0, delta};
      end
      overflow = !negate && new_freq[FREQ_W];
   end

endmodule : ch1_sweep_calc

// File: rtl/ch1_sweep.sv
// -----------------------------------------------------------------------------
// ch1_sweep
//   Channel-1 frequency sweep unit. Holds a shadow copy of the channel
//   frequency captured on restart, periodically recomputes it on 128 Hz
//   sweep ticks and writes the result back to the frequency register.
//   Overflow of an upward sweep, or clearing the negate bit after a
//   subtracting calculation was used, disables the channel.
//
//   Ports:
//     dyfa_1mhz     in  1        APU clock (rising edge)
//     napu_reset    in  1        asynchronous active-low reset
//     sweep_tick    in  1        one-cycle 128 Hz frame-sequencer step
//     ch1_restart   in  1        one-cycle channel trigger
//     sweep_period  in  PER_W    NR10[6:4]
//     sweep_negate  in  1        NR10[3], 1 = subtract
//     sweep_shift   in  SHIFT_W  NR10[2:0]
//     freq_in       in  FREQ_W   current channel frequency, sampled on restart
//     freq_out      out FREQ_W   last written frequency (registered)
//     freq_wr       out 1        one-cycle load strobe for freq_out
//     ch1_sweep_off out 1        one-cycle channel-disable pulse
//     sweep_en      out 1        sweep-enable flag (registered)
// -----------------------------------------------------------------------------
module ch1_sweep
   import apu_pkg::*;
#(
   parameter int FREQ_W  = FREQ_W_DEF,
   parameter int PER_W   = PER_W_DEF,
   parameter int SHIFT_W = SHIFT_W_DEF
) (
   input  logic               dyfa_1mhz,
   input  logic               napu_reset,
   input  logic               sweep_tick,
   input  logic               ch1_restart,
   input  logic [PER_W-1:0]   sweep_period,
   input  logic               sweep_negate,
   input  logic [SHIFT_W-1:0] sweep_shift,
   input  logic [FREQ_W-1:0]  freq_in,
   output logic [FREQ_W-1:0]  freq_out,
   output logic               freq_wr,
   output logic               ch1_sweep_off,
   output logic               sweep_en
);

   localparam logic [SWEEP_TIMER_W-1:0] TIMER_ONE     = SWEEP_TIMER_W'(1);
   localparam logic [SWEEP_TIMER_W-1:0] TIMER_RELOAD0 = SWEEP_TIMER_W'(SWEEP_PERIOD0_RELOAD);

   sweep_state_e               state;
   logic [FREQ_W-1:0]          shadow;
   logic [SWEEP_TIMER_W-1:0]   timer;
   logic                       neg_used;

   logic [FREQ_W:0]            calc_new;
   logic                       calc_ovf;
   logic                       unused_carry;
   logic [SWEEP_TIMER_W-1:0]   reload_val;
   logic                       timer_expired;
   logic                       neg_quirk;
   logic                       shift_nz;
   logic                       period_nz;

   ch1_sweep_calc #(
      .FREQ_W  (FREQ_W),
      .SHIFT_W (SHIFT_W)
   ) u_calc (
      .shadow   (shadow),
      .negate   (sweep_negate),
      .shift    (sweep_shift),
      .new_freq (calc_new),
      .overflow (calc_ovf)
   );

   // The carry is already folded into calc_ovf; only the low bits are stored.
   assign unused_carry  = calc_new[FREQ_W];

   assign shift_nz      = (sweep_shift != '0);
   assign period_nz     = (sweep_period != '0);
   // A period of 0 reloads the timer with 8 rather than 0.
   assign reload_val    = period_nz ? SWEEP_TIMER_W'(sweep_period) : TIMER_RELOAD0;
   // A timer of 0 (only possible straight out of reset) also counts as expired.
   assign timer_expired = (timer == '0) || (timer == TIMER_ONE);
   // Software cleared negate after a subtracting calculation was used.
   assign neg_quirk     = neg_used && !sweep_negate;

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others, independent of the
   // order the statements are written in.
   always_ff @(posedge dyfa_1mhz or negedge napu_reset) begin
      if (!napu_reset) begin
         state         <= SWEEP_IDLE;
         shadow        <= '0;
         timer         <= '0;
         neg_used      <= 1'b0;
         freq_out      <= '0;
         freq_wr       <= 1'b0;
         ch1_sweep_off <= 1'b0;
         sweep_en      <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         freq_wr       <= 1'b0;
         ch1_sweep_off <= 1'b0;

         if (ch1_restart) begin
            // Restart aborts any calculation in flight and swallows a
            // coincident tick.
            shadow   <= freq_in;
            timer    <= reload_val;
            neg_used <= 1'b0;
            sweep_en <= period_nz || shift_nz;
            state    <= shift_nz ? SWEEP_CHECK : SWEEP_IDLE;
         end else begin
            // The timer runs in every state; only IDLE may act on expiry.
            if (sweep_tick) begin
               timer <= timer_expired ? reload_val : timer - TIMER_ONE;
            end

            if (neg_quirk) begin
               // Takes precedence over any pending calculation so that a
               // write strobe and an off pulse never coincide.
               ch1_sweep_off <= 1'b1;
               sweep_en      <= 1'b0;
               neg_used      <= 1'b0;
               state         <= SWEEP_IDLE;
            end else begin
               case (state)
                  SWEEP_IDLE: begin
                     if (sweep_tick && timer_expired && sweep_en && period_nz) begin
                        state <= SWEEP_APPLY;
                     end
                  end

                  SWEEP_CHECK: begin
                     // Overflow probe right after restart; never writes.
                     if (sweep_negate) begin
                        neg_used <= 1'b1;
                     end
                     if (calc_ovf) begin
                        ch1_sweep_off <= 1'b1;
                        sweep_en      <= 1'b0;
                     end
                     state <= SWEEP_IDLE;
                  end

                  SWEEP_APPLY: begin
                     if (sweep_negate) begin
                        neg_used <= 1'b1;
                     end
                     if (calc_ovf) begin
                        ch1_sweep_off <= 1'b1;
                        sweep_en      <= 1'b0;
                        state         <= SWEEP_IDLE;
                     end else if (shift_nz) begin
                        shadow   <= calc_new[FREQ_W-1:0];
                        freq_out <= calc_new[FREQ_W-1:0];
                        freq_wr  <= 1'b1;
                        state    <= SWEEP_RECHECK;
                     end else begin
                        state <= SWEEP_IDLE;
                     end
                  end

                  SWEEP_RECHECK: begin
                     // Second calculation on the freshly written shadow; it
                     // can only disable the channel, never write.
                     if (calc_ovf) begin
                        ch1_sweep_off <= 1'b1;
                        sweep_en      <= 1'b0;
                     end
                     state <= SWEEP_IDLE;
                  end

                  default: begin
                     state <= SWEEP_IDLE;
                  end
               endcase
            end
         end
      end
   end

endmodule : ch1_sweep

// File: tb/tb_ch1_sweep.sv
// -----------------------------------------------------------------------------
// tb_ch1_sweep
//   Directed bench for ch1_sweep. A cycle-level behavioural model tracks the
//   expected outputs from the sweep rules using integer arithmetic; a compare
//   process checks all outputs against it on every falling edge. Directed
//   sequences add hand-computed literal expectations at key cycles.
// -----------------------------------------------------------------------------
module tb_ch1_sweep;

   logic        clk = 1'b0;
   logic        napu_reset = 1'b1;
   logic        sweep_tick = 1'b0;
   logic        ch1_restart = 1'b0;
   logic [2:0]  sweep_period = '0;
   logic        sweep_negate = 1'b0;
   logic [2:0]  sweep_shift = '0;
   logic [10:0] freq_in = '0;
   logic [10:0] freq_out;
   logic        freq_wr;
   logic        ch1_sweep_off;
   logic        sweep_en;

   int total = 0;
   int bad   = 0;

   ch1_sweep dut (
      .dyfa_1mhz     (clk),
      .napu_reset    (napu_reset),
      .sweep_tick    (sweep_tick),
      .ch1_restart   (ch1_restart),
      .sweep_period  (sweep_period),
      .sweep_negate  (sweep_negate),
      .sweep_shift   (sweep_shift),
      .freq_in       (freq_in),
      .freq_out      (freq_out),
      .freq_wr       (freq_wr),
      .ch1_sweep_off (ch1_sweep_off),
      .sweep_en      (sweep_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: what work is pending after each edge, integer math.
   // ---------------------------------------------------------------------------
   localparam int JOB_NONE    = 0;
   localparam int JOB_PROBE   = 1;  // overflow probe after restart
   localparam int JOB_SWEEP   = 2;  // tick-triggered calculation and write
   localparam int JOB_REPROBE = 3;  // probe of the just-written value

   int m_shadow = 0, m_timer = 0, m_fout = 0, m_job = JOB_NONE;
   bit m_en = 0, m_neg = 0, m_wr = 0, m_off = 0;
   int mv_rl, mv_nv;
   bit mv_ovf, mv_exp;

   always @(posedge clk or negedge napu_reset) begin
      if (!napu_reset) begin
         m_shadow = 0; m_timer = 0; m_fout = 0; m_job = JOB_NONE;
         m_en = 0; m_neg = 0; m_wr = 0; m_off = 0;
      end else begin
         m_wr   = 0;
         m_off  = 0;
         mv_rl  = (sweep_period == 0) ? 8 : int'(sweep_period);
         mv_nv  = sweep_negate ? m_shadow - (m_shadow >> sweep_shift)
                               : m_shadow + (m_shadow >> sweep_shift);
         mv_ovf = !sweep_negate && (mv_nv > 2047);
         if (ch1_restart) begin
            m_shadow = int'(freq_in);
            m_timer  = mv_rl;
            m_neg    = 0;
            m_en     = (sweep_period != 0) || (sweep_shift != 0);
            m_job    = (sweep_shift != 0) ? JOB_PROBE : JOB_NONE;
         end else begin
            mv_exp = 0;
            if (sweep_tick) begin
               if (m_timer <= 1) begin
                  m_timer = mv_rl;
                  mv_exp  = 1;
               end else begin
                  m_timer = m_timer - 1;
               end
            end
            if (m_neg && !sweep_negate) begin
               m_off = 1; m_en = 0; m_neg = 0; m_job = JOB_NONE;
            end else if (m_job == JOB_PROBE) begin
               if (sweep_negate) m_neg = 1;
               if (mv_ovf) begin m_off = 1; m_en = 0; end
               m_job = JOB_NONE;
            end else if (m_job == JOB_SWEEP) begin
               if (sweep_negate) m_neg = 1;
               if (mv_ovf) begin
                  m_off = 1; m_en = 0; m_job = JOB_NONE;
               end else if (sweep_shift != 0) begin
                  m_shadow = mv_nv; m_fout = mv_nv; m_wr = 1; m_job = JOB_REPROBE;
               end else begin
                  m_job = JOB_NONE;
               end
            end else if (m_job == JOB_REPROBE) begin
               if (mv_ovf) begin m_off = 1; m_en = 0; end
               m_job = JOB_NONE;
            end else if (mv_exp && m_en && sweep_period != 0) begin
               m_job = JOB_SWEEP;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_freq_out", 16'(freq_out), 16'(m_fout));
      check("cmp_freq_wr",  16'(freq_wr), 16'(m_wr));
      check("cmp_off",      16'(ch1_sweep_off), 16'(m_off));
      check("cmp_sweep_en", 16'(sweep_en), 16'(m_en));
      check("cmp_wr_off_excl", 16'(freq_wr & ch1_sweep_off), 16'(0));
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after a rising edge.
   // ---------------------------------------------------------------------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sweep_tick = 1'b1;
      cyc(1);
      sweep_tick = 1'b0;
   endtask

   task automatic restart(input logic [10:0] f, input logic [2:0] p,
                          input logic [2:0] s, input logic neg);
      freq_in      = f;
      sweep_period = p;
      sweep_shift  = s;
      sweep_negate = neg;
      ch1_restart  = 1'b1;
      cyc(1);
      ch1_restart  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int events;

      // Reset state, then ticks with sweep disabled do nothing.
      #1 napu_reset = 1'b0;
      cyc(2);
      check("rst_freq_out", 16'(freq_out), 16'h000);
      check("rst_freq_wr", 16'(freq_wr), 16'h0);
      check("rst_off", 16'(ch1_sweep_off), 16'h0);
      check("rst_sweep_en", 16'(sweep_en), 16'h0);
      napu_reset = 1'b1;
      cyc(1);
      events = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (freq_wr || ch1_sweep_off) events++;
         cyc(1);
         if (freq_wr || ch1_sweep_off) events++;
      end
      check("rst_ticks_idle", 16'(events), 16'h0);

      // 0x700 + 0x380 overflows in the post-restart probe.
      restart(11'h700, 3'd1, 3'd1, 1'b0);
      check("ovf_en_after_restart", 16'(sweep_en), 16'h1);
      cyc(1);
      check("ovf_off_pulse", 16'(ch1_sweep_off), 16'h1);
      check("ovf_no_wr", 16'(freq_wr), 16'h0);
      check("ovf_en_cleared", 16'(sweep_en), 16'h0);
      cyc(1);
      check("ovf_off_single", 16'(ch1_sweep_off), 16'h0);

      // Period 2: second tick writes 0x180; recheck of 0x240 is clean.
      restart(11'h100, 3'd2, 3'd1, 1'b0);
      cyc(1);
      tick();
      check("p2_tick1_no_wr", 16'(freq_wr), 16'h0);
      tick();
      check("p2_tick2_wr_not_yet", 16'(freq_wr), 16'h0);
      cyc(1);
      check("p2_wr", 16'(freq_wr), 16'h1);
      check("p2_freq_out", 16'(freq_out), 16'h180);
      check("p2_model_fout", 16'(m_fout), 16'h180);
      cyc(1);
      check("p2_recheck_no_off", 16'(ch1_sweep_off), 16'h0);

      // Negate: 0x400 - 0x100 = 0x300, then clearing negate disables.
      restart(11'h400, 3'd1, 3'd2, 1'b1);
      cyc(1);
      tick();
      cyc(1);
      check("neg_wr", 16'(freq_wr), 16'h1);
      check("neg_freq_out", 16'(freq_out), 16'h300);
      cyc(1);
      sweep_negate = 1'b0;
      cyc(1);
      check("neg_quirk_off", 16'(ch1_sweep_off), 16'h1);
      check("neg_quirk_en", 16'(sweep_en), 16'h0);
      cyc(1);
      check("neg_quirk_single", 16'(ch1_sweep_off), 16'h0);

      // Period 0: 16 ticks never sweep; timer must be back at 8 afterwards.
      restart(11'h100, 3'd0, 3'd3, 1'b0);
      cyc(1);
      check("p0_en", 16'(sweep_en), 16'h1);
      events = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (freq_wr || ch1_sweep_off) events++;
         cyc(1);
         if (freq_wr || ch1_sweep_off) events++;
      end
      check("p0_no_events", 16'(events), 16'h0);
      check("p0_model_timer", 16'(m_timer), 16'd8);
      sweep_period = 3'd1;
      events = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (freq_wr) events++;
         cyc(1);
         if (freq_wr) events++;
      end
      check("p0_timer_8_no_early_wr", 16'(events), 16'h0);
      tick();
      cyc(1);
      check("p0_late_wr", 16'(freq_wr), 16'h1);
      check("p0_late_freq_out", 16'(freq_out), 16'h120);

      // Shift 0: 0x7FF + 0x7FF overflows at the tick calculation.
      restart(11'h7FF, 3'd1, 3'd0, 1'b0);
      tick();
      cyc(1);
      check("s0_ovf_off", 16'(ch1_sweep_off), 16'h1);
      check("s0_ovf_no_wr", 16'(freq_wr), 16'h0);
      // Shift 0 without overflow: no write, no off, still enabled.
      restart(11'h100, 3'd1, 3'd0, 1'b0);
      tick();
      cyc(1);
      check("s0_no_wr", 16'(freq_wr), 16'h0);
      check("s0_no_off", 16'(ch1_sweep_off), 16'h0);
      check("s0_en", 16'(sweep_en), 16'h1);

      // Restart with coincident tick, then restart aborting an APPLY.
      sweep_tick = 1'b1;
      restart(11'h200, 3'd1, 3'd1, 1'b0);
      sweep_tick = 1'b0;
      cyc(2);
      check("rt_tick_ignored", 16'(freq_wr), 16'h0);
      tick();
      freq_in     = 11'h080;
      ch1_restart = 1'b1;
      cyc(1);
      ch1_restart = 1'b0;
      check("rt_abort_no_wr", 16'(freq_wr), 16'h0);
      cyc(1);
      check("rt_check_no_wr", 16'(freq_wr), 16'h0);
      tick();
      cyc(1);
      check("rt_new_shadow_wr", 16'(freq_wr), 16'h1);
      check("rt_new_shadow_val", 16'(freq_out), 16'h0C0);

      // 0x500 -> 0x780 written, recheck 0x780 + 0x3C0 overflows.
      restart(11'h500, 3'd1, 3'd1, 1'b0);
      cyc(1);
      tick();
      cyc(1);
      check("rc_wr", 16'(freq_wr), 16'h1);
      check("rc_freq_out", 16'(freq_out), 16'h780);
      cyc(1);
      check("rc_off", 16'(ch1_sweep_off), 16'h1);
      check("rc_en", 16'(sweep_en), 16'h0);

      // Reset asserted while an APPLY is pending.
      restart(11'h100, 3'd1, 3'd1, 1'b0);
      cyc(1);
      tick();
      napu_reset = 1'b0;
      #1;
      check("mid_rst_wr", 16'(freq_wr), 16'h0);
      check("mid_rst_freq_out", 16'(freq_out), 16'h000);
      check("mid_rst_en", 16'(sweep_en), 16'h0);
      cyc(2);
      napu_reset = 1'b1;
      cyc(2);
      check("post_rst_wr", 16'(freq_wr), 16'h0);
      check("post_rst_en", 16'(sweep_en), 16'h0);

      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ch1_sweep

// File: doc/ch1_sweep.md
Name: ch1_sweep

Overview:
- Channel-1 frequency sweep unit (NR10 behaviour). Sits directly downstream of the channel-1 register block.
- Consumes the NR10 fields, the current 11-bit frequency, the channel-1 restart pulse and the 128 Hz frame-sequencer tick.
- Produces a new frequency with a write strobe back into the frequency counter load path, plus a channel-disable pulse on overflow.

Parameters:
- FREQ_W, 11, frequency/shadow width.
- PER_W, 3, sweep period field width.
- SHIFT_W, 3, sweep shift field width.

Ports:
- dyfa_1mhz  input  1  APU clock; all state updates on rising edge.
- napu_reset  input  1  asynchronous active-low reset.
- sweep_tick  input  1  one-cycle enable, 128 Hz frame-sequencer step.
- ch1_restart  input  1  one-cycle trigger pulse (NR14 bit 7 write).
- sweep_period  input  PER_W  NR10[6:4], true polarity.
- sweep_negate  input  1  NR10[3]; 1 = subtract.
- sweep_shift  input  SHIFT_W  NR10[2:0].
- freq_in  input  FREQ_W  current NR13/NR14 frequency, sampled on restart.
- freq_out  output  FREQ_W  last computed frequency, registered.
- freq_wr  output  1  one-cycle strobe; load freq_out into the frequency register and counter.
- ch1_sweep_off  output  1  one-cycle pulse; disable channel 1.
- sweep_en  output  1  internal sweep-enable flag, registered.

Behaviour:
- Reset: freq_out=0, freq_wr=0, ch1_sweep_off=0, sweep_en=0, shadow=0, timer=0, neg_used=0, state=IDLE.
- Calculation is combinational, shared by all states.
  - delta = shadow >> sweep_shift.
  - new = shadow - delta if negate, else shadow + delta, computed FREQ_W+1 wide.
  - overflow = !negate && new[FREQ_W].
  - Subtraction never underflows.
- Reload value: rl = 8 when sweep_period==0, else sweep_period. timer is 4 bits.
- FSM states: IDLE, CHECK, APPLY, RECHECK.
- Restart (edge N) has highest priority. It aborts any state and ignores a simultaneous tick.
  - shadow<=freq_in; timer<=rl; neg_used<=0.
  - sweep_en<=(period!=0 || shift!=0).
  - state<=CHECK if shift!=0, else IDLE.
- CHECK (edge N+1): if overflow, ch1_sweep_off=1 for that cycle and sweep_en<=0. No write. Set neg_used if negate. Go to IDLE.
- Tick in IDLE with no restart:
  - timer<=timer-1.
  - If timer<=1 it expires: timer<=rl.
  - If it expires and sweep_en && sweep_period!=0, state<=APPLY.
  - Ticks arriving in CHECK/APPLY/RECHECK only decrement/reload the timer; they do not start a new calculation.
- APPLY (next edge): set neg_used if negate.
  - Overflow: ch1_sweep_off pulse, sweep_en<=0, go to IDLE.
  - Else if shift!=0: shadow<=new, freq_out<=new, freq_wr=1 for one cycle, go to RECHECK.
  - Else (shift==0): no write, go to IDLE. The overflow check still applies.
- RECHECK (next edge): recompute on the updated shadow. On overflow: ch1_sweep_off pulse, sweep_en<=0. Never writes. Go to IDLE.
- Latencies:
  - Restart to off pulse: 1 cycle.
  - Tick to freq_wr: 1 cycle.
  - Tick to recheck off pulse: 2 cycles.
- Negate quirk: if neg_used==1 and sweep_negate is 0 (cleared by software), fire one ch1_sweep_off pulse and set sweep_en<=0, neg_used<=0. The check is evaluated every cycle outside restart.
- Register field changes mid-operation take effect at the next calculation. No latching beyond shadow.
- Reset asserted mid-operation returns to reset values immediately. No strobe completes.
- freq_wr and ch1_sweep_off are never high in the same cycle.

Decomposition:
- Shared package apu_pkg:
  - sweep FSM state encoding: IDLE=0, CHECK=1, APPLY=2, RECHECK=3.
  - FREQ_W/PER_W/SHIFT_W defaults.
  - constant SWEEP_PERIOD0_RELOAD=8.
- One sub-module, ch1_sweep_calc: purely combinational shifter and adder/subtractor producing new[FREQ_W:0] and overflow. Kept separate for unit testing.

Test Plan:
- Reset -> freq_out=0x000, freq_wr=0, ch1_sweep_off=0, sweep_en=0; ticks produce nothing.
- freq_in=0x700, shift=1, add, period=1, restart -> 0x700+0x380=0xA80 overflows; ch1_sweep_off pulses 1 cycle after restart; no freq_wr.
- freq_in=0x100, period=2, shift=1, add, restart, then two ticks:
  - First tick: nothing.
  - Second tick: freq_wr with freq_out=0x180 one cycle later.
  - RECHECK of 0x240 raises no off pulse.
- freq_in=0x400, period=1, shift=2, negate, restart, tick -> freq_wr with 0x300. Then clear negate -> ch1_sweep_off pulse next cycle, sweep_en=0.
- period=0, shift=3, restart, 16 ticks -> no freq_wr and no off; timer reloads 8.
- Restart asserted in the same cycle as a tick, and again during APPLY -> no freq_wr from the aborted calculation; shadow=new freq_in; timer=rl.
